// File: rtl/valve_step_sequencer.sv
// valve_step_sequencer: runs a stored program of valve steps. Each step
// drives a valve pattern, hands its delay to the downstream counter with a
// one-cycle start pulse, and waits for the counter to report completion.
module valve_step_sequencer #(
    parameter int NUM_VALVES = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    prog_we,
    input  logic [ADDR_W-1:0]       prog_addr,
    input  logic [NUM_VALVES+12:0]  prog_wdata,
    input  logic [ADDR_W:0]         step_count,
    input  logic                    loop_en,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    count_done,
    output logic                    count_start,
    output logic [9:0]              delay,
    output logic [2:0]              delay_unit,
    output logic [NUM_VALVES-1:0]   valve_out,
    output logic [ADDR_W-1:0]       cur_step,
    output logic                    busy,
    output logic                    seq_done,
    output logic                    prog_err
);

    localparam int ENTRY_W = NUM_VALVES + 13;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    // Counter handshake: count_start is high for exactly one cycle (ISSUE)
    // and tells the counter to load delay/delay_unit, which stay stable
    // until the next pulse. count_done is honoured only while in WAIT; any
    // other cycle it is ignored, and stop always wins over it.
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT,
        S_NEXT,
        S_DONE
    } state_t;

    state_t state, state_nx;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [ENTRY_W-1:0] entry;
    logic [ADDR_W-1:0]  idx, idx_nx;
    logic [ADDR_W:0]    count_lat;
    logic [ADDR_W:0]    count_clamped;
    logic               loop_lat;
    logic [NUM_VALVES-1:0] valve_r;
    logic [9:0]         delay_r;
    logic [2:0]         unit_r;
    logic               err_r;
    logic               last_step;
    logic               load_entry;
    logic               clear_valve;
    logic               latch_run;

    assign entry         = mem[idx];
    assign count_clamped = (step_count > DEPTH_C) ? DEPTH_C : step_count;
    assign last_step     = ({1'b0, idx} == (count_lat - 1'b1));

    assign count_start = (state == S_ISSUE);
    assign busy        = (state != S_IDLE);
    assign seq_done    = (state == S_DONE);
    assign prog_err    = err_r;
    assign cur_step    = idx;
    assign valve_out   = valve_r;
    assign delay       = delay_r;
    assign delay_unit  = unit_r;

    // Program memory: writes land only while idle; no reset so contents
    // survive a reset of the sequencer.
    always_ff @(posedge clk) begin
        if (prog_we && !busy) begin
            mem[prog_addr] <= prog_wdata;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; stop overrides every other transition.
    always_comb begin
        state_nx    = state;
        idx_nx      = idx;
        load_entry  = 1'b0;
        clear_valve = 1'b0;
        latch_run   = 1'b0;
        if (stop && (state != S_IDLE)) begin
            state_nx    = S_IDLE;
            clear_valve = 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && (step_count != '0)) begin
                        state_nx  = S_FETCH;
                        idx_nx    = '0;
                        latch_run = 1'b1;
                    end
                end
                S_FETCH: begin
                    state_nx   = S_ISSUE;
                    load_entry = 1'b1;
                end
                S_ISSUE: begin
                    // A zero delay needs no counter wait, but the pulse
                    // is still issued so the counter sees every step.
                    state_nx = (delay_r != '0) ? S_WAIT : S_NEXT;
                end
                S_WAIT: begin
                    if (count_done) begin
                        state_nx = S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (last_step) begin
                        if (loop_lat) begin
                            state_nx = S_FETCH;
                            idx_nx   = '0;
                        end else begin
                            state_nx    = S_DONE;
                            clear_valve = 1'b1;
                        end
                    end else begin
                        state_nx = S_FETCH;
                        idx_nx   = idx + 1'b1;
                    end
                end
                S_DONE: begin
                    state_nx = S_IDLE;
                end
                default: begin
                    state_nx = S_IDLE;
                end
            endcase
        end
    end

    // Datapath registers: step index, run parameters, current step outputs
    // and the rejected-write flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx       <= '0;
            count_lat <= '0;
            loop_lat  <= 1'b0;
            valve_r   <= '0;
            delay_r   <= '0;
            unit_r    <= '0;
            err_r     <= 1'b0;
        end else begin
            idx   <= idx_nx;
            err_r <= prog_we && busy;
            if (latch_run) begin
                count_lat <= count_clamped;
                loop_lat  <= loop_en;
            end
            if (load_entry) begin
                valve_r <= entry[ENTRY_W-1:13];
                unit_r  <= entry[12:10];
                delay_r <= entry[9:0];
            end else if (clear_valve) begin
                valve_r <= '0;
            end
        end
    end

endmodule

// File: tb/tb_valve_step_sequencer.sv
// Testbench for valve_step_sequencer: directed scenarios plus randomized
// programs, checked against a step-list model and a counter responder.
module tb_valve_step_sequencer;

    localparam int NV    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int EW    = NV + 13;
    localparam int PW    = AW + EW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          prog_we = 1'b0;
    logic [AW-1:0] prog_addr = '0;
    logic [EW-1:0] prog_wdata = '0;
    logic [AW:0]   step_count = '0;
    logic          loop_en = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          count_done;
    logic          count_start;
    logic [9:0]    delay;
    logic [2:0]    delay_unit;
    logic [NV-1:0] valve_out;
    logic [AW-1:0] cur_step;
    logic          busy;
    logic          seq_done;
    logic          prog_err;

    logic count_done_auto = 1'b0;
    logic count_done_man  = 1'b0;
    assign count_done = count_done_auto | count_done_man;

    int chk_cnt   = 0;
    int pass_cnt  = 0;
    int pulse_cnt = 0;
    int done_cnt  = 0;
    int err_cnt   = 0;
    int exp_done  = 0;
    int ncyc      = 0;
    int exp_next_t = 0;
    int timer     = 0;
    bit have_prev = 1'b0;
    bit prev_busy = 1'b0;
    bit auto_en   = 1'b1;
    logic [NV-1:0] last_valve = '0;

    logic [PW-1:0] exp_q[$];
    logic [EW-1:0] model_mem [DEPTH];

    valve_step_sequencer #(.NUM_VALVES(NV), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_wdata (prog_wdata),
        .step_count (step_count),
        .loop_en    (loop_en),
        .start      (start),
        .stop       (stop),
        .count_done (count_done),
        .count_start(count_start),
        .delay      (delay),
        .delay_unit (delay_unit),
        .valve_out  (valve_out),
        .cur_step   (cur_step),
        .busy       (busy),
        .seq_done   (seq_done),
        .prog_err   (prog_err)
    );

    // Clock.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Monitor, scoreboard and counter responder, all sampled on the falling edge.
    always @(negedge clk) begin
        ncyc++;
        if (rst) begin
            have_prev = 1'b0;
            prev_busy = 1'b0;
            timer = 0;
            count_done_auto = 1'b0;
            last_valve = '0;
        end else begin
            // Counter model: raise count_done 'delay' cycles after a start pulse.
            if (count_start && auto_en) begin
                timer = int'(delay);
                count_done_auto = 1'b0;
            end else if (timer != 0) begin
                timer--;
                count_done_auto = (timer == 0);
            end else begin
                count_done_auto = 1'b0;
            end
            if (!busy) begin
                timer = 0;
                count_done_auto = 1'b0;
                have_prev = 1'b0;
                last_valve = '0;
                check("idle_valve", valve_out, 0);
                check("idle_cstart", count_start, 0);
            end else begin
                if (!prev_busy) begin
                    exp_next_t = ncyc + 1;
                    have_prev = 1'b1;
                end
                if (count_start) begin
                    pulse_cnt++;
                    if (exp_q.size() == 0) check("extra_pulse", 1, 0);
                    else check("pulse", {cur_step, valve_out, delay_unit, delay}, exp_q.pop_front());
                    if (have_prev) check("pulse_time", ncyc, exp_next_t);
                    exp_next_t = ncyc + ((delay == 0) ? 3 : int'(delay) + 3);
                    have_prev = 1'b1;
                    last_valve = valve_out;
                end else if (seq_done) begin
                    done_cnt++;
                    check("done_valve", valve_out, 0);
                    if (have_prev) check("done_time", ncyc, exp_next_t - 1);
                end else begin
                    check("hold_valve", valve_out, last_valve);
                end
            end
            if (prog_err) err_cnt++;
            prev_busy = busy;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic write_entry(input int a, input logic [EW-1:0] d);
        prog_we = 1'b1;
        prog_addr = a[AW-1:0];
        prog_wdata = d;
        tick();
        prog_we = 1'b0;
        model_mem[a] = d;
    endtask

    // Expected start pulses for a run: steps 0..n-1, wrapping for 'extra' more.
    task automatic push_run(input int sc, input int extra);
        int n;
        n = (sc > DEPTH) ? DEPTH : sc;
        for (int i = 0; i < n + extra; i++) begin
            int s;
            logic [AW-1:0] s_idx;
            s = i % n;
            s_idx = s[AW-1:0];
            exp_q.push_back({s_idx, model_mem[s]});
        end
    endtask

    task automatic run(input int sc, input bit lp);
        step_count = sc[AW:0];
        loop_en = lp;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int t = 0;
        while (busy && t < budget) begin
            tick();
            t++;
        end
        check("idle_timeout", busy, 0);
    endtask

    task automatic wait_pulses(input int target, input int budget);
        int t = 0;
        while (pulse_cnt < target && t < budget) begin
            tick();
            t++;
        end
        check("pulse_timeout", pulse_cnt >= target, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cstart"}, count_start, 0);
        check({tag, "_delay"}, delay, 0);
        check({tag, "_unit"}, delay_unit, 0);
        check({tag, "_valve"}, valve_out, 0);
        check({tag, "_step"}, cur_step, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_sdone"}, seq_done, 0);
        check({tag, "_perr"}, prog_err, 0);
    endtask

    initial begin
        int p0;
        int d0;
        repeat (3) tick();
        check_reset_outputs("rst");
        rst = 1'b0;
        tick();

        // Basic three-step run.
        write_entry(0, {8'h01, 3'd0, 10'd10});
        write_entry(1, {8'h02, 3'd0, 10'd5});
        write_entry(2, {8'h04, 3'd0, 10'd3});
        p0 = pulse_cnt;
        push_run(3, 0);
        run(3, 1'b0);
        exp_done++;
        wait_idle(500);
        check("t1_pulses", pulse_cnt - p0, 3);
        check("t1_done", done_cnt, exp_done);
        check("t1_q", exp_q.size(), 0);

        // Looping run, then stop while waiting.
        p0 = pulse_cnt;
        push_run(3, 1);
        run(3, 1'b1);
        wait_pulses(p0 + 4, 500);
        repeat (2) tick();
        check("t2_step", cur_step, 0);
        check("t2_valve", valve_out, 8'h01);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("t2_busy", busy, 0);
        check("t2_valve_clr", valve_out, 0);
        repeat (15) tick();
        check("t2_done", done_cnt, exp_done);
        check("t2_q", exp_q.size(), 0);

        // Zero-delay steps and a rejected write during the run.
        write_entry(0, {8'h11, 3'd1, 10'd0});
        write_entry(1, {8'h22, 3'd2, 10'd4});
        write_entry(2, {8'h33, 3'd3, 10'd0});
        write_entry(3, {8'h44, 3'd7, 10'd2});
        check("t3_noerr", err_cnt, 0);
        p0 = pulse_cnt;
        push_run(4, 0);
        run(4, 1'b0);
        exp_done++;
        wait_pulses(p0 + 1, 100);
        prog_we = 1'b1;
        prog_addr = 4'd1;
        prog_wdata = ~model_mem[1];
        tick();
        prog_we = 1'b0;
        wait_idle(500);
        check("t3_err", err_cnt, 1);
        push_run(4, 0);
        run(4, 1'b0);
        exp_done++;
        wait_idle(500);
        check("t3_done", done_cnt, exp_done);
        check("t3_q", exp_q.size(), 0);

        // start with a zero step count does nothing.
        step_count = '0;
        start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("zero_cnt_busy", busy, 0);
        end
        start = 1'b0;

        // Spurious count_done in IDLE/FETCH/ISSUE, then done and stop together.
        auto_en = 1'b0;
        write_entry(0, {8'hA5, 3'd2, 10'd5});
        write_entry(1, {8'h5A, 3'd3, 10'd6});
        count_done_man = 1'b1;
        repeat (2) tick();
        check("t5_idle_busy", busy, 0);
        p0 = pulse_cnt;
        d0 = done_cnt;
        push_run(1, 0);
        step_count = 5'd2;
        loop_en = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) tick();
        count_done_man = 1'b0;
        repeat (5) tick();
        check("t5_busy", busy, 1);
        check("t5_step", cur_step, 0);
        check("t5_pulses", pulse_cnt - p0, 1);
        check("t5_nodone", done_cnt, d0);
        stop = 1'b1;
        count_done_man = 1'b1;
        tick();
        stop = 1'b0;
        count_done_man = 1'b0;
        check("t5_stop_busy", busy, 0);
        check("t5_stop_step", cur_step, 0);
        check("t5_stop_valve", valve_out, 0);
        repeat (3) tick();
        check("t5_after", busy, 0);
        check("t5_q", exp_q.size(), 0);
        auto_en = 1'b1;

        // Randomized programs.
        for (int r = 0; r < 10; r++) begin
            int sc;
            int n;
            bit lp;
            for (int a = 0; a < DEPTH; a++) begin
                logic [NV-1:0] v;
                logic [2:0] u;
                logic [9:0] dl;
                v = NV'($urandom);
                u = 3'($urandom_range(0, 7));
                dl = ($urandom_range(0, 3) == 0) ? 10'd0 : 10'($urandom_range(1, 12));
                write_entry(a, {v, u, dl});
            end
            sc = $urandom_range(0, 18);
            n = (sc > DEPTH) ? DEPTH : sc;
            lp = (r % 3 == 2);
            p0 = pulse_cnt;
            if (n == 0) begin
                run(sc, lp);
                repeat (3) tick();
                check("rnd_zero_busy", busy, 0);
            end else if (lp) begin
                int extra;
                extra = $urandom_range(1, n + 2);
                push_run(sc, extra);
                run(sc, 1'b1);
                wait_pulses(p0 + n + extra, 20000);
                stop = 1'b1;
                tick();
                stop = 1'b0;
                check("rnd_stop_busy", busy, 0);
            end else begin
                push_run(sc, 0);
                run(sc, 1'b0);
                exp_done++;
                wait_idle(20000);
            end
            repeat (2) tick();
            check("rnd_done", done_cnt, exp_done);
            check("rnd_q", exp_q.size(), 0);
        end

        // Asynchronous reset in the middle of a wait.
        write_entry(0, {8'h0F, 3'd0, 10'd0});
        write_entry(1, {8'hF0, 3'd5, 10'd50});
        p0 = pulse_cnt;
        push_run(2, 0);
        run(2, 1'b0);
        wait_pulses(p0 + 2, 100);
        repeat (3) tick();
        check("t7_pre_step", cur_step, 1);
        check("t7_pre_valve", valve_out, 8'hF0);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("t7");
        repeat (2) tick();
        rst = 1'b0;
        tick();
        check("t7_busy", busy, 0);
        check("t7_q", exp_q.size(), 0);
        check("final_err", err_cnt, 1);
        check("final_done", done_cnt, exp_done);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
